archer_projectile_ctrl: RTL and testbench
=========================================

# archer_projectile_ctrl

Generates and advances archer projectiles and publishes their per-slot positions and active flags in the packed format consumed by the projectile draw stage. A fire press spawns a projectile at the character, and each frame tick moves every active projectile horizontally. Projectiles retire at the screen edge or on a collision clear. Sits between the player input/character position logic and the VGA draw chain, running in the pixel clock domain.

## Interface
- PROJECTILE_COUNT, vga_pkg::PROJECTILE_COUNT, number of projectile slots
- PROJ_SPEED, vga_pkg::PROJ_SPEED (4), pixels moved per frame tick
- FIRE_COOLDOWN, vga_pkg::PROJ_COOLDOWN (15), frame ticks between spawns
- X_MIN, 0, leftmost legal projectile x
- X_MAX, vga_pkg::HOR_PIXELS-1, rightmost legal projectile x

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous assert, active-low
- frame_tick  in  1  one-cycle pulse per frame
- fire_btn  in  1  attack button, level, synchronous to clk
- char_x, char_y  in  12 each  character centre
- flip_hor_archer  in  1  facing: 1 = left, 0 = right
- game_active  in  2  non-zero = game running
- char_class  in  2  selected class; archer = 2
- alive  in  1  player alive
- hit_clear  in  PROJECTILE_COUNT  per-slot retire request from collision logic
- pos_x_proj, pos_y_proj  out  PROJECTILE_COUNT*12 each  slot i at [i*12 +: 12]
- projectile_animated  out  PROJECTILE_COUNT  slot active
- proj_dir  out  PROJECTILE_COUNT  slot direction, 1 = left
- fire_ack  out  1  one-cycle pulse on successful spawn

## Operation
- enable = (game_active != 0) && (char_class == 2) && alive.
- If enable is low: all slots are cleared, cooldown is 0, and the pending request is dropped on the next cycle. The FSM returns to IDLE.
- Fire request: a rising edge of fire_btn (previous-cycle register) sets fire_pending. Further edges while pending have no effect.
- hit_clear[i] clears active[i] in any state, one cycle later. This takes priority over a move of the same slot in the same cycle.
- FSM states: IDLE, MOVE, SPAWN.
  - IDLE -> MOVE on frame_tick.
  - MOVE -> SPAWN unconditionally.
  - SPAWN -> IDLE unconditionally.
  - frame_tick outside IDLE is ignored.
- MOVE, for each active slot:
  - Compute x_next in 13-bit signed: x ± PROJ_SPEED.
  - Retire the slot if x_next < X_MIN or x_next > X_MAX; otherwise store x_next.
  - y is unchanged.
  - Cooldown decrements, saturating at 0.
- SPAWN:
  - Spawn if fire_pending && cooldown == 0 && a free slot exists (occupancy after MOVE and hit_clear).
  - Use the lowest-index free slot: x = char_x, y = char_y, dir = flip_hor_archer, active = 1.
  - Cooldown loads FIRE_COOLDOWN; fire_ack is asserted.
  - fire_pending is cleared whether or not a spawn happened. A blocked request is dropped, not queued.
  - A freshly spawned slot is not moved until the next tick.
- Inactive slots keep their last x/y; consumers gate on projectile_animated.

## Timing
- All outputs are registered. The reset value of every output is 0; state = IDLE, cooldown = 0, fire_pending = 0.
- Tick sampled at cycle T (IDLE) -> MOVE at T+1 -> moved positions visible at T+2.
- SPAWN at T+2 -> spawned slot and fire_ack visible at T+3. fire_ack is high for exactly one cycle.
- fire_btn edge at cycle C -> fire_pending visible at C+1. An edge in the same cycle as SPAWN is kept for the next frame.
- hit_clear at cycle C -> projectile_animated[i] low at C+1.
- Reset asserted mid-operation clears everything immediately (asynchronously). Deassertion is synchronised externally.

## Structure
- vga_pkg gains:
  - PROJ_SPEED, PROJ_COOLDOWN, CLASS_ARCHER = 2
  - typedef enum proj_state_t {IDLE, MOVE, SPAWN}
  - PROJECTILE_COUNT already exists.
- One sub-module, proj_slot_alloc: a lowest-free-slot priority encoder over the active vector, outputting a found flag and an index.

## Test plan
- Reset, enable, char (500,300), facing right, fire edge, tick -> at T+3 slot 0 active at x = 500, y = 300, fire_ack = 1. After the next tick, x = 504.
- Facing left, char_x = 6, speed 4 -> first tick after spawn x = 2, second tick slot retires; projectile_animated[0] = 0.
- Fire edge on every frame with FIRE_COOLDOWN = 15 -> spawns spaced exactly 15 ticks apart; the slot index increments 0,1,2…
- All PROJECTILE_COUNT slots active plus fire edge -> no spawn, fire_ack stays 0, pending dropped. hit_clear[2] then fire + tick -> slot 2 reused.
- hit_clear[1] asserted in the MOVE cycle of slot 1 -> slot 1 inactive next cycle; positions of the other slots still advance.
- alive drops with 3 slots active -> next cycle projectile_animated = 0. rst_n pulse mid-MOVE -> all outputs 0 and FSM in IDLE.

Source files
------------

// File: rtl/archer_projectile_ctrl_pkg.sv
// Shared constants and types for the archer projectile controller.
// Slot count, motion speed, spawn cooldown, screen width and FSM state encoding.
package archer_projectile_ctrl_pkg;

  localparam int PROJECTILE_COUNT = 4;
  localparam int HOR_PIXELS       = 640;
  localparam int PROJ_SPEED       = 4;
  localparam int PROJ_COOLDOWN    = 15;
  localparam int COORD_W          = 12;
  localparam logic [1:0] CLASS_ARCHER = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    SPAWN = 2'd2
  } proj_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/archer_projectile_ctrl_if.sv
// Player/collision inputs and per-slot projectile outputs of the projectile controller.
// master = the controller, slave = the surrounding game logic and draw stage.
interface archer_projectile_ctrl_if #(
  parameter int N = archer_projectile_ctrl_pkg::PROJECTILE_COUNT
);

  logic          frame_tick;
  logic          fire_btn;
  logic [11:0]   char_x;
  logic [11:0]   char_y;
  logic          flip_hor_archer;
  logic [1:0]    game_active;
  logic [1:0]    char_class;
  logic          alive;
  logic [N-1:0]  hit_clear;

  logic [N*12-1:0] pos_x_proj;
  logic [N*12-1:0] pos_y_proj;
  logic [N-1:0]    projectile_animated;
  logic [N-1:0]    proj_dir;
  logic            fire_ack;

  modport master (
    input  frame_tick, fire_btn, char_x, char_y, flip_hor_archer,
           game_active, char_class, alive, hit_clear,
    output pos_x_proj, pos_y_proj, projectile_animated, proj_dir, fire_ack
  );

  modport slave (
    output frame_tick, fire_btn, char_x, char_y, flip_hor_archer,
           game_active, char_class, alive, hit_clear,
    input  pos_x_proj, pos_y_proj, projectile_animated, proj_dir, fire_ack
  );

endinterface

// File: rtl/archer_projectile_ctrl_proj_slot_alloc.sv
// Lowest-index free slot finder over an occupancy vector.
// Purely combinational; found_o low when every slot is occupied.
module proj_slot_alloc import archer_projectile_ctrl_pkg::*; #(
  parameter int N  = PROJECTILE_COUNT,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  occ_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!occ_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/archer_projectile_ctrl.sv
// Spawns archer projectiles on fire edges and steps them horizontally once per frame.
// Frame sequence IDLE -> MOVE -> SPAWN; all outputs registered, reset to zero.
module archer_projectile_ctrl #(
  parameter int PROJECTILE_COUNT = archer_projectile_ctrl_pkg::PROJECTILE_COUNT,
  parameter int PROJ_SPEED       = archer_projectile_ctrl_pkg::PROJ_SPEED,
  parameter int FIRE_COOLDOWN    = archer_projectile_ctrl_pkg::PROJ_COOLDOWN,
  parameter int X_MIN            = 0,
  parameter int X_MAX            = archer_projectile_ctrl_pkg::HOR_PIXELS - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  archer_projectile_ctrl_if.master bus
);

  import archer_projectile_ctrl_pkg::*;

  localparam int N  = PROJECTILE_COUNT;
  localparam int IW = idx_w(N);
  localparam int CW = $clog2(FIRE_COOLDOWN + 1);
  localparam logic signed [12:0] SPD  = 13'(PROJ_SPEED);
  localparam logic signed [12:0] XLO  = 13'(X_MIN);
  localparam logic signed [12:0] XHI  = 13'(X_MAX);

  proj_state_t      state_q, state_d;
  logic [N-1:0]     act_q, act_d;
  logic [N-1:0]     dir_q, dir_d;
  logic [11:0]      x_q [N];
  logic [11:0]      x_d [N];
  logic [11:0]      y_q [N];
  logic [11:0]      y_d [N];
  logic [CW-1:0]    cd_q, cd_d;
  logic             pend_q, pend_d;
  logic             btn_q;
  logic             ack_q, ack_d;

  logic             enable;
  logic             fire_rise;
  logic [N-1:0]     occ;
  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic signed [12:0] xn [N];
  logic [N*12-1:0]  px, py;

  assign enable    = (bus.game_active != 2'd0) && (bus.char_class == CLASS_ARCHER) && bus.alive;
  assign fire_rise = bus.fire_btn && !btn_q;
  // Collision clears beat both motion and the free-slot search in the same cycle.
  assign occ       = act_q & ~bus.hit_clear;

  proj_slot_alloc #(.N(N), .IW(IW)) u_alloc (
    .occ_i   (occ),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      xn[i] = $signed({1'b0, x_q[i]}) + (dir_q[i] ? -SPD : SPD);
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = occ;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    cd_d    = cd_q;
    ack_d   = 1'b0;
    pend_d  = pend_q | fire_rise;
    if (!enable) begin
      state_d = IDLE;
      act_d   = '0;
      cd_d    = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.frame_tick) state_d = MOVE;
        MOVE: begin
          state_d = SPAWN;
          for (int i = 0; i < N; i++) begin
            if (occ[i]) begin
              if (xn[i] < XLO || xn[i] > XHI) act_d[i] = 1'b0;
              else                            x_d[i]   = xn[i][11:0];
            end
          end
          if (cd_q != '0) cd_d = cd_q - CW'(1);
        end
        SPAWN: begin
          state_d = IDLE;
          // A press landing on this very cycle survives into the next frame.
          pend_d  = fire_rise;
          if (pend_q && cd_q == '0 && free_found) begin
            act_d[free_idx] = 1'b1;
            x_d[free_idx]   = bus.char_x;
            y_d[free_idx]   = bus.char_y;
            dir_d[free_idx] = bus.flip_hor_archer;
            cd_d            = CW'(FIRE_COOLDOWN);
            ack_d           = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      act_q   <= '0;
      dir_q   <= '0;
      cd_q    <= '0;
      pend_q  <= 1'b0;
      btn_q   <= 1'b0;
      ack_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      dir_q   <= dir_d;
      cd_q    <= cd_d;
      pend_q  <= pend_d;
      btn_q   <= bus.fire_btn;
      ack_q   <= ack_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    px = '0;
    py = '0;
    for (int i = 0; i < N; i++) begin
      px[i*12 +: 12] = x_q[i];
      py[i*12 +: 12] = y_q[i];
    end
  end

  assign bus.pos_x_proj          = px;
  assign bus.pos_y_proj          = py;
  assign bus.projectile_animated = act_q;
  assign bus.proj_dir            = dir_q;
  assign bus.fire_ack            = ack_q;

endmodule

// File: tb/tb_archer_projectile_ctrl.sv
// Bench for archer_projectile_ctrl: directed scenarios plus randomized frames,
// checked against a frame-level projectile model.
module tb_archer_projectile_ctrl;

  import archer_projectile_ctrl_pkg::*;

  localparam int N = PROJECTILE_COUNT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  archer_projectile_ctrl_if #(.N(N)) bus();

  archer_projectile_ctrl #(.PROJECTILE_COUNT(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level model: a list of slots, a cooldown counter and a pending request.
  bit m_act [N];
  bit m_dir [N];
  int m_x   [N];
  int m_y   [N];
  int m_cd;
  bit m_pend;
  bit m_ack;

  logic [N*12-1:0] exp_x, exp_y;
  logic [N-1:0]    exp_act, exp_dir;
  logic            ack_at, ack_after;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_cd = 0; m_pend = 0; m_ack = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_act[i] = 0;
    m_cd = 0; m_pend = 0;
  endtask

  task automatic model_frame();
    int nx;
    bit done;
    m_ack = 0;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        nx = m_x[i] + (m_dir[i] ? -PROJ_SPEED : PROJ_SPEED);
        if (nx < 0 || nx > HOR_PIXELS - 1) m_act[i] = 0;
        else m_x[i] = nx;
      end
    end
    if (m_cd > 0) m_cd--;
    if (m_pend && m_cd == 0) begin
      done = 0;
      for (int i = 0; i < N; i++) begin
        if (!done && !m_act[i]) begin
          m_act[i] = 1; m_x[i] = int'(bus.char_x); m_y[i] = int'(bus.char_y);
          m_dir[i] = bus.flip_hor_archer;
          m_cd = PROJ_COOLDOWN; m_ack = 1; done = 1;
        end
      end
    end
    m_pend = 0;
  endtask

  task automatic build_exp();
    for (int i = 0; i < N; i++) begin
      exp_x[i*12 +: 12] = 12'(m_x[i]);
      exp_y[i*12 +: 12] = 12'(m_y[i]);
      exp_act[i]        = m_act[i];
      exp_dir[i]        = m_dir[i];
    end
  endtask

  task automatic press_fire();
    bus.fire_btn = 1'b1;
    step();
    bus.fire_btn = 1'b0;
    step();
    m_pend = 1;
  endtask

  task automatic disable_cycle();
    bus.alive = 1'b0;
    step();
    bus.alive = 1'b1;
    step();
    model_clear();
  endtask

  task automatic do_hit(input logic [N-1:0] mask);
    bus.hit_clear = mask;
    step();
    bus.hit_clear = '0;
    for (int i = 0; i < N; i++) if (mask[i]) m_act[i] = 0;
  endtask

  // One frame from an IDLE controller; a long tick stays high through MOVE and SPAWN.
  task automatic run_frame(input bit long_tick);
    bus.frame_tick = 1'b1;
    step();
    if (!long_tick) bus.frame_tick = 1'b0;
    step();
    step();
    bus.frame_tick = 1'b0;
    ack_at = bus.fire_ack;
    step();
    ack_after = bus.fire_ack;
    model_frame();
    build_exp();
  endtask

  task automatic test_reset();
    bus.frame_tick = 0; bus.fire_btn = 0; bus.char_x = 0; bus.char_y = 0;
    bus.flip_hor_archer = 0; bus.game_active = 2'd1; bus.char_class = CLASS_ARCHER;
    bus.alive = 1; bus.hit_clear = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) step();
    checks++; if (bus.projectile_animated !== '0) begin errors++; $display("FAIL reset_act: got %h expected 0", bus.projectile_animated); end
    checks++; if (bus.pos_x_proj !== '0 || bus.pos_y_proj !== '0) begin errors++; $display("FAIL reset_pos: got x=%h y=%h expected 0", bus.pos_x_proj, bus.pos_y_proj); end
    checks++; if (bus.proj_dir !== '0 || bus.fire_ack !== 1'b0) begin errors++; $display("FAIL reset_dir_ack: got dir=%h ack=%b expected 0", bus.proj_dir, bus.fire_ack); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_spawn_basic();
    bus.char_x = 12'd500; bus.char_y = 12'd300; bus.flip_hor_archer = 0;
    press_fire();
    run_frame(0);
    checks++; if (ack_at !== 1'b1 || ack_after !== 1'b0) begin errors++; $display("FAIL spawn_ack: got %b,%b expected 1,0", ack_at, ack_after); end
    checks++; if (bus.pos_x_proj[11:0] !== 12'd500 || bus.pos_y_proj[11:0] !== 12'd300) begin errors++; $display("FAIL spawn_pos: got %0d,%0d expected 500,300", bus.pos_x_proj[11:0], bus.pos_y_proj[11:0]); end
    checks++; if (bus.projectile_animated !== exp_act) begin errors++; $display("FAIL spawn_act: got %b expected %b", bus.projectile_animated, exp_act); end
    run_frame(0);
    checks++; if (bus.pos_x_proj[11:0] !== 12'd504) begin errors++; $display("FAIL spawn_move: got %0d expected 504", bus.pos_x_proj[11:0]); end
    checks++; if (ack_at !== 1'b0) begin errors++; $display("FAIL spawn_noack: got %b expected 0", ack_at); end
  endtask

  task automatic test_left_retire();
    disable_cycle();
    bus.char_x = 12'd6; bus.char_y = 12'd40; bus.flip_hor_archer = 1;
    press_fire();
    run_frame(0);
    checks++; if (bus.pos_x_proj[11:0] !== 12'd6 || bus.proj_dir[0] !== 1'b1) begin errors++; $display("FAIL left_spawn: got x=%0d dir=%b expected 6,1", bus.pos_x_proj[11:0], bus.proj_dir[0]); end
    run_frame(0);
    checks++; if (bus.pos_x_proj[11:0] !== 12'd2 || bus.projectile_animated[0] !== 1'b1) begin errors++; $display("FAIL left_move: got x=%0d act=%b expected 2,1", bus.pos_x_proj[11:0], bus.projectile_animated[0]); end
    run_frame(0);
    checks++; if (bus.projectile_animated[0] !== 1'b0) begin errors++; $display("FAIL left_retire: got %b expected 0", bus.projectile_animated[0]); end
    checks++; if (bus.pos_x_proj !== exp_x) begin errors++; $display("FAIL left_keep_x: got %h expected %h", bus.pos_x_proj, exp_x); end
  endtask

  task automatic test_cooldown();
    int acks[$];
    disable_cycle();
    bus.char_x = 12'd10; bus.char_y = 12'd50; bus.flip_hor_archer = 0;
    for (int f = 0; f < 34; f++) begin
      press_fire();
      run_frame(0);
      checks++; if (ack_at !== m_ack) begin errors++; $display("FAIL cd_ack f=%0d: got %b expected %b", f, ack_at, m_ack); end
      checks++; if (bus.projectile_animated !== exp_act || bus.pos_x_proj !== exp_x) begin errors++; $display("FAIL cd_slots f=%0d: got %b/%h expected %b/%h", f, bus.projectile_animated, bus.pos_x_proj, exp_act, exp_x); end
      if (ack_at === 1'b1) acks.push_back(f);
    end
    checks++;
    if (acks.size() != 3 || acks[0] != 0 || acks[1] != 15 || acks[2] != 30) begin
      errors++; $display("FAIL cd_spacing: got %0d spawns (%p) expected frames 0,15,30", acks.size(), acks);
    end
    checks++; if (bus.projectile_animated !== 4'b0111) begin errors++; $display("FAIL cd_index: got %b expected 0111", bus.projectile_animated); end
  endtask

  task automatic test_full();
    int guard;
    guard = 0;
    while ((m_act[0] + m_act[1] + m_act[2] + m_act[3]) < 4 && guard < 40) begin
      press_fire();
      run_frame(0);
      checks++; if (ack_at !== m_ack) begin errors++; $display("FAIL full_fill_ack: got %b expected %b", ack_at, m_ack); end
      guard++;
    end
    repeat (16) run_frame(0);
    checks++; if (bus.projectile_animated !== 4'b1111) begin errors++; $display("FAIL full_occ: got %b expected 1111", bus.projectile_animated); end
    bus.char_x = 12'd77; bus.char_y = 12'd88;
    press_fire();
    run_frame(0);
    checks++; if (ack_at !== 1'b0 || ack_after !== 1'b0) begin errors++; $display("FAIL full_blocked: got %b,%b expected 0,0", ack_at, ack_after); end
    do_hit(4'b0100);
    checks++; if (bus.projectile_animated !== 4'b1011) begin errors++; $display("FAIL full_hit2: got %b expected 1011", bus.projectile_animated); end
    run_frame(0);
    checks++; if (ack_at !== 1'b0 || bus.projectile_animated[2] !== 1'b0) begin errors++; $display("FAIL full_dropped: got ack=%b act2=%b expected 0,0", ack_at, bus.projectile_animated[2]); end
    press_fire();
    run_frame(0);
    checks++; if (ack_at !== 1'b1 || bus.pos_x_proj[24 +: 12] !== 12'd77 || bus.pos_y_proj[24 +: 12] !== 12'd88) begin errors++; $display("FAIL full_reuse2: got ack=%b x=%0d y=%0d expected 1,77,88", ack_at, bus.pos_x_proj[24 +: 12], bus.pos_y_proj[24 +: 12]); end
    checks++; if (bus.projectile_animated !== exp_act || bus.pos_x_proj !== exp_x) begin errors++; $display("FAIL full_model: got %b/%h expected %b/%h", bus.projectile_animated, bus.pos_x_proj, exp_act, exp_x); end
  endtask

  task automatic test_hit_in_move();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    bus.hit_clear = 4'b0010;
    step();
    bus.hit_clear = '0;
    m_act[1] = 0;
    model_frame();
    build_exp();
    checks++; if (bus.projectile_animated !== exp_act) begin errors++; $display("FAIL move_hit_act: got %b expected %b", bus.projectile_animated, exp_act); end
    checks++; if (bus.pos_x_proj !== exp_x) begin errors++; $display("FAIL move_hit_pos: got %h expected %h", bus.pos_x_proj, exp_x); end
    step();
    step();
    checks++; if (bus.fire_ack !== 1'b0) begin errors++; $display("FAIL move_hit_ack: got %b expected 0", bus.fire_ack); end
  endtask

  task automatic test_alive_drop();
    checks++; if (bus.projectile_animated !== 4'b1101) begin errors++; $display("FAIL alive_pre: got %b expected 1101", bus.projectile_animated); end
    bus.alive = 1'b0;
    step();
    model_clear();
    build_exp();
    checks++; if (bus.projectile_animated !== '0) begin errors++; $display("FAIL alive_clear: got %b expected 0", bus.projectile_animated); end
    checks++; if (bus.pos_x_proj !== exp_x) begin errors++; $display("FAIL alive_keep_x: got %h expected %h", bus.pos_x_proj, exp_x); end
    bus.alive = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    bus.char_x = 12'd320; bus.char_y = 12'd100; bus.flip_hor_archer = 1;
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
    bus.fire_btn = 1'b1;
    step();
    checks++; if (bus.fire_ack !== 1'b0) begin errors++; $display("FAIL b2b_noack: got %b expected 0", bus.fire_ack); end
    bus.fire_btn = 1'b0;
    step();
    model_frame();
    m_pend = 1;
    run_frame(0);
    checks++; if (ack_at !== 1'b1 || bus.projectile_animated !== exp_act || bus.pos_x_proj !== exp_x) begin errors++; $display("FAIL b2b_kept: got ack=%b act=%b x=%h expected 1,%b,%h", ack_at, bus.projectile_animated, bus.pos_x_proj, exp_act, exp_x); end
  endtask

  task automatic test_reset_mid();
    press_fire();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.projectile_animated !== '0 || bus.pos_x_proj !== '0 || bus.pos_y_proj !== '0 || bus.proj_dir !== '0 || bus.fire_ack !== 1'b0) begin errors++; $display("FAIL rst_mid: got act=%b x=%h y=%h dir=%b ack=%b expected all 0", bus.projectile_animated, bus.pos_x_proj, bus.pos_y_proj, bus.proj_dir, bus.fire_ack); end
    step();
    rst_n = 1'b1;
    step();
    model_reset();
    bus.char_x = 12'd100; bus.char_y = 12'd200; bus.flip_hor_archer = 0;
    press_fire();
    run_frame(0);
    checks++; if (ack_at !== 1'b1 || bus.pos_x_proj !== exp_x || bus.projectile_animated !== exp_act) begin errors++; $display("FAIL rst_idle: got ack=%b x=%h act=%b expected 1,%h,%b", ack_at, bus.pos_x_proj, bus.projectile_animated, exp_x, exp_act); end
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 3);
      if (r == 0 || r == 3) begin
        bus.char_x = 12'($urandom_range(0, HOR_PIXELS - 1));
        bus.char_y = 12'($urandom_range(0, 479));
        bus.flip_hor_archer = 1'($urandom_range(0, 1));
        press_fire();
      end else if (r == 1) begin
        do_hit(N'($urandom_range(0, (1 << N) - 1)));
      end
      run_frame(1'($urandom_range(0, 1)));
      checks++; if (ack_at !== m_ack || ack_after !== 1'b0) begin errors++; $display("FAIL rnd_ack it=%0d: got %b,%b expected %b,0", it, ack_at, ack_after, m_ack); end
      checks++; if (bus.projectile_animated !== exp_act || bus.proj_dir !== exp_dir) begin errors++; $display("FAIL rnd_act it=%0d: got %b/%b expected %b/%b", it, bus.projectile_animated, bus.proj_dir, exp_act, exp_dir); end
      checks++; if (bus.pos_x_proj !== exp_x || bus.pos_y_proj !== exp_y) begin errors++; $display("FAIL rnd_pos it=%0d: got %h/%h expected %h/%h", it, bus.pos_x_proj, bus.pos_y_proj, exp_x, exp_y); end
    end
  endtask

  initial begin
    test_reset();
    test_spawn_basic();
    test_left_retire();
    test_cooldown();
    test_full();
    test_hit_in_move();
    test_alive_drop();
    test_back_to_back();
    test_reset_mid();
    disable_cycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
